// File: rtl/branch_resolver.sv
// Branch resolver: compares two operands one CHUNK-wide slice per cycle,
// most significant slice first, then produces the taken decision and the
// resolved next PC through a valid/ready response handshake.
module branch_resolver #(
   parameter int WORDSIZE = 64,
   parameter int CHUNK    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          req_funct3,
   input  logic [WORDSIZE-1:0] req_a,
   input  logic [WORDSIZE-1:0] req_b,
   input  logic [WORDSIZE-1:0] req_pc,
   input  logic [WORDSIZE-1:0] req_imm,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_taken,
   output logic [WORDSIZE-1:0] resp_next_pc,
   output logic                resp_illegal
);

   localparam int NCHUNK = WORDSIZE / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic [2:0]          r_funct3;
   logic [WORDSIZE-1:0] r_a;
   logic [WORDSIZE-1:0] r_b;
   logic [WORDSIZE-1:0] r_pc;
   logic [WORDSIZE-1:0] r_imm;
   logic [IDXW-1:0]     r_idx;
   logic                r_gt;
   logic                r_lt;
   logic                r_taken;
   logic                r_illegal;
   logic [WORDSIZE-1:0] r_next_pc;

   logic [CHUNK-1:0]    w_slice_a;
   logic [CHUNK-1:0]    w_slice_b;
   logic                w_is_signed;
   logic                w_decided;
   logic                w_gt_next;
   logic                w_lt_next;
   logic                w_eq_final;
   logic                w_taken;
   logic                w_illegal;
   logic [WORDSIZE-1:0] w_next_pc;

   // Handshake outputs come straight from the state register.
   assign req_ready    = (r_state == IDLE);
   assign resp_valid   = (r_state == DONE);
   assign resp_taken   = r_taken;
   assign resp_illegal = r_illegal;
   assign resp_next_pc = r_next_pc;

   assign w_is_signed = (r_funct3 == 3'b100) || (r_funct3 == 3'b101);
   assign w_illegal   = (r_funct3 == 3'b010) || (r_funct3 == 3'b011);

   // Select the current slice of both operands; for signed compares the sign
   // bit of the top slice is flipped so an unsigned compare orders correctly.
   always_comb begin
      w_slice_a = '0;
      w_slice_b = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (r_idx == IDXW'(k)) begin
            w_slice_a = r_a[WORDSIZE-1-k*CHUNK -: CHUNK];
            w_slice_b = r_b[WORDSIZE-1-k*CHUNK -: CHUNK];
         end
      end
      if (w_is_signed && (r_idx == '0)) begin
         w_slice_a[CHUNK-1] = ~w_slice_a[CHUNK-1];
         w_slice_b[CHUNK-1] = ~w_slice_b[CHUNK-1];
      end
   end

   // Only the first differing slice may set gt/lt; once decided the result
   // is frozen, and equality is simply "neither gt nor lt".
   always_comb begin
      w_decided  = r_gt | r_lt;
      w_gt_next  = r_gt | (!w_decided && (w_slice_a > w_slice_b));
      w_lt_next  = r_lt | (!w_decided && (w_slice_a < w_slice_b));
      w_eq_final = !(w_gt_next | w_lt_next);
   end

   // Map funct3 and the final comparison to the taken decision and next PC.
   always_comb begin
      w_taken = 1'b0;
      case (r_funct3)
         3'b000:  w_taken = w_eq_final;
         3'b001:  w_taken = !w_eq_final;
         3'b100:  w_taken = w_lt_next;
         3'b101:  w_taken = !w_lt_next;
         3'b110:  w_taken = w_lt_next;
         3'b111:  w_taken = !w_lt_next;
         default: w_taken = 1'b0;
      endcase
      w_next_pc = w_taken ? (r_pc + r_imm) : (r_pc + WORDSIZE'(4));
   end

   // State register; reset wins over flush, flush wins over everything else.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: accept in IDLE, walk the slices in CMP, and hold the
   // result in DONE until the consumer takes it.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_state_next = CMP;
            end
         end
         CMP: begin
            if (r_idx == LAST_IDX) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (resp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
      if (flush) begin
         w_state_next = IDLE;
      end
   end

   // Datapath: latch the request, accumulate slice comparisons, and register
   // the response once on the last slice so it stays stable during backpressure.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_funct3  <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_pc      <= '0;
         r_imm     <= '0;
         r_idx     <= '0;
         r_gt      <= 1'b0;
         r_lt      <= 1'b0;
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
         r_next_pc <= '0;
      end else if (flush) begin
         r_idx <= '0;
         r_gt  <= 1'b0;
         r_lt  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_funct3 <= req_funct3;
                  r_a      <= req_a;
                  r_b      <= req_b;
                  r_pc     <= req_pc;
                  r_imm    <= req_imm;
                  r_idx    <= '0;
                  r_gt     <= 1'b0;
                  r_lt     <= 1'b0;
               end
            end
            CMP: begin
               r_gt <= w_gt_next;
               r_lt <= w_lt_next;
               if (r_idx == LAST_IDX) begin
                  r_idx     <= '0;
                  r_taken   <= w_taken;
                  r_illegal <= w_illegal;
                  r_next_pc <= w_next_pc;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: a table of branch vectors run
// through a scoreboard, plus hand sequences for stall, flush and reset.
module tb_branch_resolver;

   localparam int W  = 64;
   localparam int NC = 4;

   typedef struct {
      logic [2:0]   f3;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] pc;
      logic [W-1:0] imm;
      logic         taken;
      logic         illegal;
      logic [W-1:0] npc;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         req_valid;
   logic         req_ready;
   logic [2:0]   req_funct3;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [W-1:0] req_pc;
   logic [W-1:0] req_imm;
   logic         resp_valid;
   logic         resp_ready;
   logic         resp_taken;
   logic [W-1:0] resp_next_pc;
   logic         resp_illegal;

   vec_t vecs[12];
   vec_t sbq[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   branch_resolver #(.WORDSIZE(W), .CHUNK(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_funct3   (req_funct3),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_pc       (req_pc),
      .req_imm      (req_imm),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_taken   (resp_taken),
      .resp_next_pc (resp_next_pc),
      .resp_illegal (resp_illegal)
   );

   // Single comparison point: every check counts here.
   task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request, wait for the accepting edge, and record its expectation.
   task automatic applyStimulus(input vec_t v);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      checkVal("req_ready_before_issue", W'(req_ready), W'(1));
      req_funct3 = v.f3;
      req_a      = v.a;
      req_b      = v.b;
      req_pc     = v.pc;
      req_imm    = v.imm;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
      sbq.push_back(v);
   endtask

   // Count edges from the accepting edge until resp_valid, bounded.
   task automatic waitResp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!resp_valid) begin
         tests++;
         fails++;
         $display("[TB] FAIL resp_timeout: got no resp_valid expected resp_valid within 20 cycles");
      end
   endtask

   // Pop the oldest expectation and compare it against the presented response.
   task automatic checkOutput(input int lat);
      vec_t e;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL scoreboard_empty: got response expected none");
         return;
      end
      e = sbq.pop_front();
      checkVal("latency", W'(lat), W'(NC));
      checkVal("resp_valid", W'(resp_valid), W'(1));
      checkVal("resp_taken", W'(resp_taken), W'(e.taken));
      checkVal("resp_illegal", W'(resp_illegal), W'(e.illegal));
      checkVal("resp_next_pc", resp_next_pc, e.npc);
   endtask

   // Full transaction with resp_ready already high: issue, wait, check, drain.
   task automatic runVector(input vec_t v);
      int lat;
      applyStimulus(v);
      waitResp(lat);
      checkOutput(lat);
      tick();
      checkVal("resp_valid_after_drain", W'(resp_valid), W'(0));
      checkVal("req_ready_after_drain", W'(req_ready), W'(1));
   endtask

   initial begin
      int           lat;
      int           rises;
      logic         snapTaken;
      logic         snapIllegal;
      logic [W-1:0] snapPc;

      vecs[0]  = '{3'b000, 64'h5, 64'h5, 64'h1000, 64'h20, 1'b1, 1'b0, 64'h1020};
      vecs[1]  = '{3'b100, 64'h2, 64'h8000_0000_0000_0002, 64'h2000, 64'h40, 1'b0, 1'b0, 64'h2004};
      vecs[2]  = '{3'b110, 64'h2, 64'h8000_0000_0000_0002, 64'h2000, 64'h40, 1'b1, 1'b0, 64'h2040};
      vecs[3]  = '{3'b001, 64'h1000_0000_0000_0005, 64'h1000_0000_0000_0001, 64'h3000, 64'h100, 1'b1, 1'b0, 64'h3100};
      vecs[4]  = '{3'b101, 64'h5, 64'h5, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b1, 1'b0, 64'h10};
      vecs[5]  = '{3'b010, 64'h1, 64'h2, 64'h4000, 64'h80, 1'b0, 1'b1, 64'h4004};
      vecs[6]  = '{3'b111, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5000, 64'h8, 1'b0, 1'b0, 64'h5004};
      vecs[7]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h6000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 64'h5FF0};
      vecs[8]  = '{3'b001, 64'hABCD, 64'hABCD, 64'h7000, 64'h10, 1'b0, 1'b0, 64'h7004};
      vecs[9]  = '{3'b011, 64'h3, 64'h3, 64'h8000, 64'h10, 1'b0, 1'b1, 64'h8004};
      vecs[10] = '{3'b101, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h100, 64'h10, 1'b1, 1'b0, 64'h110};
      vecs[11] = '{3'b110, 64'h0001_0000_0000_FFFF, 64'h0002_0000_0000_0000, 64'h700, 64'h30, 1'b1, 1'b0, 64'h730};

      rst_n      = 1'b0;
      flush      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      req_funct3 = '0;
      req_a      = '0;
      req_b      = '0;
      req_pc     = '0;
      req_imm    = '0;
      repeat (3) tick();
      rst_n = 1'b1;

      $display("[TB] reset state");
      checkVal("reset_req_ready", W'(req_ready), W'(1));
      checkVal("reset_resp_valid", W'(resp_valid), W'(0));
      checkVal("reset_resp_taken", W'(resp_taken), W'(0));
      checkVal("reset_resp_illegal", W'(resp_illegal), W'(0));
      checkVal("reset_resp_next_pc", resp_next_pc, W'(0));

      $display("[TB] vector table");
      for (int i = 0; i < 12; i++) begin
         runVector(vecs[i]);
      end

      $display("[TB] backpressure stall");
      resp_ready = 1'b0;
      applyStimulus(vecs[5]);
      waitResp(lat);
      checkOutput(lat);
      snapTaken   = resp_taken;
      snapIllegal = resp_illegal;
      snapPc      = resp_next_pc;
      req_funct3  = 3'b000;
      req_a       = 64'h9;
      req_b       = 64'h9;
      req_pc      = 64'h9999;
      req_valid   = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checkVal("stall_resp_valid", W'(resp_valid), W'(1));
         checkVal("stall_req_ready", W'(req_ready), W'(0));
         checkVal("stall_taken", W'(resp_taken), W'(snapTaken));
         checkVal("stall_illegal", W'(resp_illegal), W'(snapIllegal));
         checkVal("stall_next_pc", resp_next_pc, snapPc);
      end
      resp_ready = 1'b1;
      tick();
      req_valid = 1'b0;
      checkVal("release_resp_valid", W'(resp_valid), W'(0));
      checkVal("release_no_same_edge_accept", W'(req_ready), W'(1));
      tick();
      checkVal("release_still_idle", W'(req_ready), W'(1));

      $display("[TB] flush in second compare cycle");
      applyStimulus(vecs[3]);
      void'(sbq.pop_back());
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkVal("flush_req_ready", W'(req_ready), W'(1));
      checkVal("flush_resp_valid", W'(resp_valid), W'(0));
      rises = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (resp_valid) rises++;
      end
      checkVal("flush_no_response", W'(rises), W'(0));
      runVector(vecs[0]);

      $display("[TB] reset in second compare cycle");
      applyStimulus(vecs[7]);
      void'(sbq.pop_back());
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkVal("midreset_req_ready", W'(req_ready), W'(1));
      checkVal("midreset_next_pc", resp_next_pc, W'(0));
      rises = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (resp_valid) rises++;
      end
      checkVal("midreset_no_response", W'(rises), W'(0));
      runVector(vecs[1]);

      $display("[TB] flush beats request in idle");
      req_valid = 1'b1;
      flush     = 1'b1;
      tick();
      req_valid = 1'b0;
      flush     = 1'b0;
      checkVal("flush_blocks_accept", W'(req_ready), W'(1));
      rises = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (resp_valid) rises++;
      end
      checkVal("flush_idle_no_response", W'(rises), W'(0));
      runVector(vecs[11]);

      checkVal("scoreboard_drained", W'(sbq.size()), W'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
